fpu_byte_link: RTL and testbench
================================

Name: fpu_byte_link

Overview:
Chip-side endpoint of the 8-bit tagged pin protocol for the 16-bit FPU.
- Deserializes tagged operand/opcode bytes from the host into 16-bit operands A, B and a 4-bit opcode, and issues them to the FPU core over a valid/ready handshake.
- Serializes the core's 16-bit result and status back to the host as tagged bytes.
- Sits between the top-level io_in/io_out pins and the FPU core.

Parameters:
TIMEOUT, 64, max cycles in WAIT for res_valid before a timeout result is sent (>=2)
OP_W, 4, opcode width taken from in_val[OP_W-1:0]

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
in_tag  input  2  00 idle, 01 operand A byte, 10 operand B byte, 11 opcode byte
in_val  input  8  input byte (maps to io_in[9:2])
out_tag  output  2  00 idle, 01 result byte, 11 status byte
out_val  output  8  output byte (maps to io_out[9:2])
ready  output  1  link up; 0 in reset, 1 from the first cycle after reset deasserts
cmd_valid  output  1  command to core valid
cmd_ready  input  1  core accepts command
cmd_a  output  16  operand A
cmd_b  output  16  operand B
cmd_op  output  OP_W  opcode
res_valid  input  1  one-cycle result pulse from core
res_data  input  16  result
res_flags  input  5  {invalid, divzero, overflow, underflow, inexact}

Behaviour:
- Reset (synchronous):
  - out_tag=00, out_val=00, ready=0, cmd_valid=0.
  - A=B=0, byte pointers a_ptr=b_ptr=HI, prev_tag=11, overrun=0, FSM=IDLE.
  - Reset mid-operation discards any pending command or result.
- Operand capture (every non-reset cycle, any FSM state):
  - Tag 01 writes A[15:8] if a_ptr=HI, else A[7:0]. a_ptr toggles.
  - Tag 10 does the same for B with b_ptr.
  - Tag 00 changes nothing.
- Opcode event: in_tag=11 && prev_tag!=11. Holding 11 fires once. 11 held through reset never fires.
  - Every opcode event resets a_ptr=b_ptr=HI, in any state.
- FSM states: IDLE, ISSUE, WAIT, SEND_HI, SEND_LO, SEND_ST.
  - IDLE: an opcode event latches cmd_a=A, cmd_b=B, cmd_op=in_val[OP_W-1:0], then -> ISSUE. cmd_valid is 1 the next cycle.
  - ISSUE: hold cmd_valid and cmd_* stable until cmd_ready. On the accept edge, cmd_valid drops and FSM -> WAIT with timer=0.
  - WAIT: res_valid latches res_data/res_flags -> SEND_HI. timer reaching TIMEOUT-1 without res_valid latches 16'h7E00 and flags 0, sets the timeout bit, -> SEND_HI.
  - SEND_HI drives out_tag=01, out_val=result[15:8], -> SEND_LO.
  - SEND_LO drives out_tag=01, out_val=result[7:0], -> SEND_ST.
  - SEND_ST drives out_tag=11, out_val={overrun, timeout, 0, flags[4:0]}. Then clear overrun and timeout, -> IDLE.
  - Outside SEND_* states, out_tag=00 and out_val=00.
- Opcode event outside IDLE: command dropped, sticky overrun=1 (reported in the next status byte). Operand writes still update A/B, which preloads the next command.
- res_valid outside WAIT is ignored.
- Latency:
  - Opcode sampled at edge N -> cmd_valid high after edge N.
  - res_valid sampled at edge M -> high byte after M, low byte after M+1, status after M+2, idle after M+3.

Decomposition:
- Package fpu_link_pkg holds:
  - tag enum: TAG_IDLE=00, TAG_A=01, TAG_B=10, TAG_OP=11 (output reuses 01/11).
  - opcode constants: OP_ADD=1, OP_SUB=2, OP_MUL=3, OP_DIV=4.
  - FSM state enum, status-byte bit positions, TIMEOUT_RESULT=16'h7E00.
- One natural sub-module, fpu_link_tx: 3-byte result/status serializer with a load pulse, driving out_tag/out_val.
- Deserializer and issue FSM stay in the top.

Test Plan:
- Basic subtract: after ready=1, send A bytes 4E,54 (tag 01), B bytes 4E,54 (tag 10), opcode 02 (tag 11); stub core with cmd_ready=1 returns 0x0000, flags 0 after 3 cycles -> cmd_a=cmd_b=0x4E54, cmd_op=2; output (01,00),(01,00),(11,00), then (00,00).
- Held opcode across reset: in_tag=11 through reset and 5 further cycles -> cmd_valid never rises; ready rises the cycle after reset deasserts.
- Pointer resync: A bytes 11,22,33, then opcode 01 -> cmd_a=0x3322. Then A bytes AA,BB and opcode 01 -> cmd_a=0xAABB.
- Backpressure and overrun: cmd_ready held low 4 cycles -> cmd_valid and cmd_* stable throughout. A second opcode event during WAIT is dropped. Result 0x3C00 -> bytes 3C,00, status 0x80.
- Timeout: core never answers -> exactly TIMEOUT cycles after accept, output (01,7E),(01,00),(11,40). Next command's status has bit 6 clear.
- Reset mid-send: assert reset during SEND_LO -> next cycle out_tag=00, out_val=00, cmd_valid=0; no residual bytes after release.

Source files
------------

// File: rtl/fpu_link_pkg.sv
// Shared definitions for the FPU byte link: pin tags, opcodes, FSM states,
// status-byte layout and the status packing helper.
package fpu_link_pkg;

    // Input pin tags; the output side reuses TAG_A (result byte) and TAG_OP (status byte).
    typedef enum logic [1:0] {
        TAG_IDLE = 2'b00,
        TAG_A    = 2'b01,
        TAG_B    = 2'b10,
        TAG_OP   = 2'b11
    } tag_e;

    // Opcodes understood by the FPU core.
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd3;
    localparam logic [3:0] OP_DIV = 4'd4;

    // Issue/collect FSM of the link top.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_SEND_HI = 3'd3,
        ST_SEND_LO = 3'd4,
        ST_SEND_ST = 3'd5
    } link_state_e;

    // Which byte the serializer currently presents on the pins.
    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_HI   = 2'd1,
        TX_LO   = 2'd2,
        TX_ST   = 2'd3
    } tx_state_e;

    // Operand byte pointer values.
    localparam logic PTR_HI = 1'b0;
    localparam logic PTR_LO = 1'b1;

    // Status byte layout: {overrun, timeout, 0, flags[4:0]}.
    localparam int STAT_OVERRUN_BIT = 7;
    localparam int STAT_TIMEOUT_BIT = 6;
    localparam int STAT_FLAGS_W     = 5;

    // Canonical quiet NaN reported when the core never answers.
    localparam logic [15:0] TIMEOUT_RESULT = 16'h7E00;

    // Build the status byte from its fields.
    function automatic logic [7:0] pack_status(
        input logic                    overrun,
        input logic                    timeout,
        input logic [STAT_FLAGS_W-1:0] flags
    );
        logic [7:0] s;
        s = 8'h00;
        s[STAT_OVERRUN_BIT]   = overrun;
        s[STAT_TIMEOUT_BIT]   = timeout;
        s[STAT_FLAGS_W-1:0]   = flags;
        return s;
    endfunction

endpackage

// File: rtl/fpu_link_tx.sv
// Result/status serializer: on a load pulse presents the result high byte,
// then the low byte, then the status byte, then returns the pins to idle.
// The overrun bit is sampled when the status byte is emitted so that drops
// seen while the result bytes are still going out are reported too.
module fpu_link_tx
    import fpu_link_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load_i,
    input  logic [15:0] data_i,
    input  logic [4:0]  flags_i,
    input  logic        timeout_i,
    input  logic        overrun_i,
    output logic [1:0]  out_tag_o,
    output logic [7:0]  out_val_o
);

    tx_state_e   state_q;
    logic [7:0]  lo_q;
    logic [4:0]  flags_q;
    logic        timeout_q;
    logic [1:0]  out_tag_q;
    logic [7:0]  out_val_q;

    // Serializer sequencing with registered pin outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= TX_IDLE;
            lo_q      <= 8'h00;
            flags_q   <= 5'd0;
            timeout_q <= 1'b0;
            out_tag_q <= TAG_IDLE;
            out_val_q <= 8'h00;
        end else begin
            case (state_q)
                TX_HI: begin
                    out_tag_q <= TAG_A;
                    out_val_q <= lo_q;
                    state_q   <= TX_LO;
                end
                TX_LO: begin
                    out_tag_q <= TAG_OP;
                    out_val_q <= pack_status(overrun_i, timeout_q, flags_q);
                    state_q   <= TX_ST;
                end
                default: begin
                    if (load_i) begin
                        out_tag_q <= TAG_A;
                        out_val_q <= data_i[15:8];
                        lo_q      <= data_i[7:0];
                        flags_q   <= flags_i;
                        timeout_q <= timeout_i;
                        state_q   <= TX_HI;
                    end else begin
                        out_tag_q <= TAG_IDLE;
                        out_val_q <= 8'h00;
                        state_q   <= TX_IDLE;
                    end
                end
            endcase
        end
    end

    assign out_tag_o = out_tag_q;
    assign out_val_o = out_val_q;

endmodule

// File: rtl/fpu_byte_link.sv
// Chip-side endpoint of the 8-bit tagged pin protocol for the 16-bit FPU.
// Assembles operands and opcode from tagged bytes, issues a command over a
// valid/ready handshake, waits for the result (with timeout) and streams the
// result and status back through the serializer.
module fpu_byte_link
    import fpu_link_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int OP_W    = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      in_tag,
    input  logic [7:0]      in_val,
    output logic [1:0]      out_tag,
    output logic [7:0]      out_val,
    output logic            ready,
    output logic            cmd_valid,
    input  logic            cmd_ready,
    output logic [15:0]     cmd_a,
    output logic [15:0]     cmd_b,
    output logic [OP_W-1:0] cmd_op,
    input  logic            res_valid,
    input  logic [15:0]     res_data,
    input  logic [4:0]      res_flags
);

    localparam int              TMR_W    = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    // Operand assembly state.
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic        a_ptr_q, a_ptr_d;
    logic        b_ptr_q, b_ptr_d;
    logic [1:0]  prev_tag_q;

    // Issue/collect state.
    link_state_e     state_q;
    logic            cmd_valid_q;
    logic [15:0]     cmd_a_q;
    logic [15:0]     cmd_b_q;
    logic [OP_W-1:0] cmd_op_q;
    logic [TMR_W-1:0] timer_q;
    logic            overrun_q;
    logic            ready_q;

    // Event and serializer-load decode.
    logic        op_event_s;
    logic        drop_s;
    logic        load_s;
    logic [15:0] load_data_s;
    logic [4:0]  load_flags_s;
    logic        load_timeout_s;
    logic        in_val_unused_s;

    // Opcode bytes above OP_W are not part of the command.
    assign in_val_unused_s = ^in_val;

    // A held opcode tag fires once; prev_tag resets to TAG_OP so a tag held through reset never fires.
    assign op_event_s = (in_tag == TAG_OP) && (prev_tag_q != TAG_OP);
    assign drop_s     = op_event_s && (state_q != ST_IDLE);

    // Next operand bytes and pointers; an opcode event resynchronises both pointers.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        a_ptr_d = a_ptr_q;
        b_ptr_d = b_ptr_q;
        case (in_tag)
            TAG_A: begin
                if (a_ptr_q == PTR_HI) begin
                    a_d[15:8] = in_val;
                end else begin
                    a_d[7:0] = in_val;
                end
                a_ptr_d = ~a_ptr_q;
            end
            TAG_B: begin
                if (b_ptr_q == PTR_HI) begin
                    b_d[15:8] = in_val;
                end else begin
                    b_d[7:0] = in_val;
                end
                b_ptr_d = ~b_ptr_q;
            end
            TAG_OP: begin
                if (op_event_s) begin
                    a_ptr_d = PTR_HI;
                    b_ptr_d = PTR_HI;
                end else begin
                    a_ptr_d = a_ptr_q;
                    b_ptr_d = b_ptr_q;
                end
            end
            default: begin
                a_d = a_q;
                b_d = b_q;
            end
        endcase
    end

    // Operand registers, tag history and link-up flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_q        <= 16'h0000;
            b_q        <= 16'h0000;
            a_ptr_q    <= PTR_HI;
            b_ptr_q    <= PTR_HI;
            prev_tag_q <= TAG_OP;
            ready_q    <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            a_ptr_q    <= a_ptr_d;
            b_ptr_q    <= b_ptr_d;
            prev_tag_q <= in_tag;
            ready_q    <= 1'b1;
        end
    end

    // Serializer load: a real result wins over a timeout on the same cycle.
    always_comb begin
        load_s         = 1'b0;
        load_data_s    = res_data;
        load_flags_s   = res_flags;
        load_timeout_s = 1'b0;
        if (state_q == ST_WAIT) begin
            if (res_valid) begin
                load_s = 1'b1;
            end else if (timer_q == TMR_LAST) begin
                load_s         = 1'b1;
                load_data_s    = TIMEOUT_RESULT;
                load_flags_s   = 5'd0;
                load_timeout_s = 1'b1;
            end else begin
                load_s = 1'b0;
            end
        end else begin
            load_s = 1'b0;
        end
    end

    // Issue/collect FSM with registered command outputs and sticky overrun.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cmd_valid_q <= 1'b0;
            cmd_a_q     <= 16'h0000;
            cmd_b_q     <= 16'h0000;
            cmd_op_q    <= '0;
            timer_q     <= '0;
            overrun_q   <= 1'b0;
        end else begin
            if (drop_s) begin
                overrun_q <= 1'b1;
            end else if (state_q == ST_SEND_ST) begin
                overrun_q <= 1'b0;
            end else begin
                overrun_q <= overrun_q;
            end

            case (state_q)
                ST_IDLE: begin
                    if (op_event_s) begin
                        cmd_a_q     <= a_q;
                        cmd_b_q     <= b_q;
                        cmd_op_q    <= in_val[OP_W-1:0];
                        cmd_valid_q <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        timer_q     <= '0;
                        state_q     <= ST_WAIT;
                    end else begin
                        state_q <= ST_ISSUE;
                    end
                end
                ST_WAIT: begin
                    if (load_s) begin
                        state_q <= ST_SEND_HI;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                ST_SEND_HI: begin
                    state_q <= ST_SEND_LO;
                end
                ST_SEND_LO: begin
                    state_q <= ST_SEND_ST;
                end
                ST_SEND_ST: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    cmd_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    fpu_link_tx u_tx (
        .clock     (clock),
        .reset     (reset),
        .load_i    (load_s),
        .data_i    (load_data_s),
        .flags_i   (load_flags_s),
        .timeout_i (load_timeout_s),
        .overrun_i (overrun_q | drop_s),
        .out_tag_o (out_tag),
        .out_val_o (out_val)
    );

    assign ready     = ready_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_a     = cmd_a_q;
    assign cmd_b     = cmd_b_q;
    assign cmd_op    = cmd_op_q;

endmodule

// File: tb/tb_fpu_byte_link.sv
// Directed bench for fpu_byte_link: linear sequence of hand-computed vectors.
module tb_fpu_byte_link;

    localparam int TB_TIMEOUT = 8;

    logic        clock;
    logic        reset;
    logic [1:0]  in_tag;
    logic [7:0]  in_val;
    logic [1:0]  out_tag;
    logic [7:0]  out_val;
    logic        ready;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic [3:0]  cmd_op;
    logic        res_valid;
    logic [15:0] res_data;
    logic [4:0]  res_flags;

    int vectors;
    int miscompares;

    fpu_byte_link #(.TIMEOUT(TB_TIMEOUT), .OP_W(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_tag    (in_tag),
        .in_val    (in_val),
        .out_tag   (out_tag),
        .out_val   (out_val),
        .ready     (ready),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_op    (cmd_op),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_flags (res_flags)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [1:0] t, input logic [7:0] v);
        in_tag = t;
        in_val = v;
        tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] t, input logic [7:0] v);
        chk(tag, {22'd0, out_tag, out_val}, {22'd0, t, v});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset     = 1'b1;
        in_tag    = 2'b00;
        in_val    = 8'h00;
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        res_data  = 16'h0000;
        res_flags = 5'd0;

        // Reset state
        tick(); tick(); tick();
        chk_out("rst_out", 2'b00, 8'h00);
        chk("rst_ready", ready, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        reset = 1'b0;
        tick();
        chk("ready_up", ready, 1);

        // Basic subtract 0x4E54 - 0x4E54
        send(2'b01, 8'h4E); send(2'b01, 8'h54);
        send(2'b10, 8'h4E); send(2'b10, 8'h54);
        send(2'b11, 8'h02);
        chk("sub_valid", cmd_valid, 1);
        chk("sub_a", cmd_a, 32'h4E54);
        chk("sub_b", cmd_b, 32'h4E54);
        chk("sub_op", cmd_op, 2);
        in_tag = 2'b00;
        cmd_ready = 1'b1;
        tick();
        chk("sub_accept", cmd_valid, 0);
        cmd_ready = 1'b0;
        tick(); tick();
        res_valid = 1'b1; res_data = 16'h0000; res_flags = 5'd0;
        tick();
        res_valid = 1'b0;
        chk_out("sub_hi", 2'b01, 8'h00);
        tick(); chk_out("sub_lo", 2'b01, 8'h00);
        tick(); chk_out("sub_st", 2'b11, 8'h00);
        tick(); chk_out("sub_idle", 2'b00, 8'h00);

        // Opcode tag held across reset never fires
        reset = 1'b1; in_tag = 2'b11; in_val = 8'h01;
        tick(); tick();
        chk("held_ready_rst", ready, 0);
        reset = 1'b0;
        tick();
        chk("held_ready_up", ready, 1);
        chk("held_valid0", cmd_valid, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("held_valid", cmd_valid, 0);
        end
        in_tag = 2'b00;
        tick();

        // Pointer resync: three A bytes then opcode
        send(2'b01, 8'h11); send(2'b01, 8'h22); send(2'b01, 8'h33);
        send(2'b11, 8'h01);
        chk("resync_a", cmd_a, 32'h3322);
        chk("resync_b", cmd_b, 32'h0000);
        in_tag = 2'b00; cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        res_valid = 1'b1; res_data = 16'h1234; res_flags = 5'b10101;
        tick();
        res_valid = 1'b0;
        chk_out("resync_hi", 2'b01, 8'h12);
        tick(); chk_out("resync_lo", 2'b01, 8'h34);
        tick(); chk_out("resync_st", 2'b11, 8'h15);
        tick(); chk_out("resync_idle", 2'b00, 8'h00);
        send(2'b01, 8'hAA); send(2'b01, 8'hBB);
        send(2'b10, 8'hC0); send(2'b10, 8'h01);
        send(2'b11, 8'h01);
        chk("resync2_a", cmd_a, 32'hAABB);

        // Backpressure: command stable while cmd_ready low
        in_tag = 2'b00;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_valid", cmd_valid, 1);
            chk("bp_a", cmd_a, 32'hAABB);
            chk("bp_b", cmd_b, 32'hC001);
            chk("bp_op", cmd_op, 1);
        end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk("bp_accept", cmd_valid, 0);
        // Second opcode during WAIT is dropped
        send(2'b11, 8'h03);
        chk("ovr_no_valid", cmd_valid, 0);
        chk("ovr_op_kept", cmd_op, 1);
        in_tag = 2'b00;
        tick();
        res_valid = 1'b1; res_data = 16'h3C00; res_flags = 5'd0;
        tick();
        res_valid = 1'b0;
        chk_out("ovr_hi", 2'b01, 8'h3C);
        tick(); chk_out("ovr_lo", 2'b01, 8'h00);
        tick(); chk_out("ovr_st", 2'b11, 8'h80);
        tick(); chk_out("ovr_idle", 2'b00, 8'h00);

        // Timeout: core never answers
        send(2'b11, 8'h04);
        chk("to_valid", cmd_valid, 1);
        in_tag = 2'b00; cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        for (int i = 1; i < TB_TIMEOUT; i++) begin
            tick();
            chk_out("to_wait", 2'b00, 8'h00);
        end
        tick(); chk_out("to_hi", 2'b01, 8'h7E);
        tick(); chk_out("to_lo", 2'b01, 8'h00);
        tick(); chk_out("to_st", 2'b11, 8'h40);
        tick(); chk_out("to_idle", 2'b00, 8'h00);
        // Following command: timeout bit cleared
        send(2'b11, 8'h01);
        in_tag = 2'b00; cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        res_valid = 1'b1; res_data = 16'h0001; res_flags = 5'b00001;
        tick();
        res_valid = 1'b0;
        chk_out("post_hi", 2'b01, 8'h00);
        tick(); chk_out("post_lo", 2'b01, 8'h01);
        tick(); chk_out("post_st", 2'b11, 8'h01);
        tick();

        // Reset during SEND_LO
        send(2'b11, 8'h02);
        in_tag = 2'b00; cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        res_valid = 1'b1; res_data = 16'hABCD; res_flags = 5'd0;
        tick();
        res_valid = 1'b0;
        chk_out("mid_hi", 2'b01, 8'hAB);
        tick();
        chk_out("mid_lo", 2'b01, 8'hCD);
        reset = 1'b1;
        tick();
        chk_out("mid_rst_out", 2'b00, 8'h00);
        chk("mid_rst_valid", cmd_valid, 0);
        chk("mid_rst_ready", ready, 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("mid_after", 2'b00, 8'h00);
        end
        chk("mid_ready", ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
